// File: rtl/ocm_amo_port.sv
// -----------------------------------------------------------------------------
// ocm_amo_port
//
// Purpose:
//   A core-side port that performs one read-modify-write (atomic memory
//   operation) on a shared on-chip memory (OCM). A request is captured in
//   IDLE, the port arbitrates for the OCM, reads the old word, writes the op
//   result back while the arbiter still holds the grant, and returns the old
//   value with a one-cycle acknowledge.
//
//   Sequence: IDLE -> REQ (wait for grant) -> READ -> WRITE -> RESP -> IDLE
//
// Optional feature:
//   OCM_AMO_MINMAX_EN  -- when defined, op codes 7..10 (MIN, MAX, MINU, MAXU)
//                         are executed. When undefined they are illegal ops
//                         and no comparators are built.
//
// Ports:
//   clk          in   clock, all state updates on the rising edge
//   rst          in   synchronous active-high reset
//   i_valid      in   core request strobe (ignored while o_busy)
//   i_op[3:0]    in   operation code
//   i_addr       in   word address (ADDR_BITS)
//   i_wdata[31:0]in   store / AMO operand
//   o_busy       out  high in every non-IDLE state (core stall)
//   o_ack        out  one-cycle completion pulse
//   o_rdata[31:0]out  old memory value, valid with o_ack, held until next ack
//   o_err        out  high with o_ack for an illegal op
//   o_req        out  OCM access request
//   o_done       out  OCM release strobe (high in WRITE)
//   i_grant      in   OCM grant for this port
//   o_addr       out  OCM address (ADDR_BITS)
//   o_data[31:0] out  OCM write data
//   o_dm_write   out  OCM byte write enables
//   i_data[31:0] in   OCM read data, one-cycle synchronous read
// -----------------------------------------------------------------------------
module ocm_amo_port #(
    parameter int ADDR_BITS = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_valid,
    input  logic [3:0]           i_op,
    input  logic [ADDR_BITS-1:0] i_addr,
    input  logic [31:0]          i_wdata,
    output logic                 o_busy,
    output logic                 o_ack,
    output logic [31:0]          o_rdata,
    output logic                 o_err,
    output logic                 o_req,
    output logic                 o_done,
    input  logic                 i_grant,
    output logic [ADDR_BITS-1:0] o_addr,
    output logic [31:0]          o_data,
    output logic [3:0]           o_dm_write,
    input  logic [31:0]          i_data
);

    localparam logic [3:0] OP_LOAD  = 4'd0;
    localparam logic [3:0] OP_STORE = 4'd1;
    localparam logic [3:0] OP_SWAP  = 4'd2;
    localparam logic [3:0] OP_ADD   = 4'd3;
    localparam logic [3:0] OP_AND   = 4'd4;
    localparam logic [3:0] OP_OR    = 4'd5;
    localparam logic [3:0] OP_XOR   = 4'd6;
`ifdef OCM_AMO_MINMAX_EN
    localparam logic [3:0] OP_MIN   = 4'd7;
    localparam logic [3:0] OP_MAX   = 4'd8;
    localparam logic [3:0] OP_MINU  = 4'd9;
    localparam logic [3:0] OP_MAXU  = 4'd10;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_READ,
        S_WRITE,
        S_RESP
    } state_t;

    state_t                r_state;
    logic [3:0]            r_op;
    logic [ADDR_BITS-1:0]  r_addr;
    logic [31:0]           r_wdata;
    logic                  r_busy;
    logic                  r_ack;
    logic                  r_err;
    logic                  r_req;
    logic                  r_done;
    logic [31:0]           r_rdata;

    logic                  w_legal;
    logic                  w_writes;
    logic [31:0]           w_result;

    // Op result from the old word (i_data, valid only in WRITE) and the
    // captured operand. MIN/MAX pick the operand only when strictly better,
    // so a tie keeps the old value.
    // NOTE: every always_comb output gets a default before the case so no
    // path leaves it unassigned, which would infer a latch.
    always_comb begin
        w_legal  = 1'b1;
        w_result = '0;
        case (r_op)
            OP_LOAD:  w_result = i_data;
            OP_STORE: w_result = r_wdata;
            OP_SWAP:  w_result = r_wdata;
            OP_ADD:   w_result = i_data + r_wdata;
            OP_AND:   w_result = i_data & r_wdata;
            OP_OR:    w_result = i_data | r_wdata;
            OP_XOR:   w_result = i_data ^ r_wdata;
`ifdef OCM_AMO_MINMAX_EN
            OP_MIN:   w_result = ($signed(r_wdata) < $signed(i_data)) ? r_wdata : i_data;
            OP_MAX:   w_result = ($signed(r_wdata) > $signed(i_data)) ? r_wdata : i_data;
            OP_MINU:  w_result = (r_wdata < i_data) ? r_wdata : i_data;
            OP_MAXU:  w_result = (r_wdata > i_data) ? r_wdata : i_data;
`endif
            default:  w_legal  = 1'b0;
        endcase
    end

    assign w_writes = w_legal && (r_op != OP_LOAD);

    // The OCM address is driven only while the port owns the memory.
    assign o_addr = ((r_state == S_READ) || (r_state == S_WRITE)) ? r_addr : '0;
    assign o_data = (r_state == S_WRITE) ? w_result : '0;

    // NOTE: the write enable is gated by rst combinationally rather than
    // through the register, so a reset that lands in WRITE cannot let the
    // memory commit a write on that same edge.
    assign o_dm_write = ((r_state == S_WRITE) && w_writes && !rst) ? 4'hF : 4'h0;

    assign o_busy  = r_busy;
    assign o_ack   = r_ack;
    assign o_err   = r_err;
    assign o_req   = r_req;
    assign o_done  = r_done;
    assign o_rdata = r_rdata;

    // Single FSM; status outputs are registered for the state being entered.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_op    <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_busy  <= 1'b0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_req   <= 1'b0;
            r_done  <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_ack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_valid) begin
                        r_op    <= i_op;
                        r_addr  <= i_addr;
                        r_wdata <= i_wdata;
                        r_busy  <= 1'b1;
                        r_req   <= 1'b1;
                        r_state <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (i_grant) begin
                        r_state <= S_READ;
                    end
                end
                S_READ: begin
                    // Grant is not re-checked: the arbiter holds it until done.
                    r_done  <= 1'b1;
                    r_state <= S_WRITE;
                end
                S_WRITE: begin
                    r_rdata <= w_legal ? i_data : 32'h0;
                    r_err   <= !w_legal;
                    r_ack   <= 1'b1;
                    r_req   <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_RESP;
                end
                S_RESP: begin
                    r_err   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_req   <= 1'b0;
                    r_done  <= 1'b0;
                    r_err   <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
